// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file with hardware clear.
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Minimum of one bit so a single-entry file still gets a counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    int unsigned v;
    w = 1;
    v = 2;
    while (v < n) begin
      w++;
      v = v * 2;
    end
    return w;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry once after reset or on request, then reports ready.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int MEM_SIZE       = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  ready
);

  localparam int unsigned       CNT_W     = clog2(MEM_SIZE);
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(MEM_SIZE - 1);
  localparam state_e            RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
    // Registered so ready is low while reset is held, even when reset lands in READY.
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = ADDR_WIDTH'(cnt_q);
  assign ready    = ready_q;

endmodule

// File: rtl/regfile_multiport_clr.sv
// Register file: one write port, READ_PORTS registered read ports, optional bypass,
// range checking with an error pulse, and a hardware clear sequencer.
module regfile_multiport_clr
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 3,
  parameter int MEM_SIZE       = 8,
  parameter int READ_PORTS     = 2,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             iClear,
  input  logic                             iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]            iWriteAddress,
  input  logic [DATA_WIDTH-1:0]            iDataIn,
  input  logic [READ_PORTS-1:0]            iReadEnable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
  output logic [READ_PORTS*DATA_WIDTH-1:0] oDataOut,
  output logic [READ_PORTS-1:0]            oReadValid,
  output logic                             oReady,
  output logic                             oError
);

  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < LIMIT);
  endfunction

  logic [DATA_WIDTH-1:0]            mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0]            mem_d [MEM_SIZE];
  logic [READ_PORTS*DATA_WIDTH-1:0] data_q, data_d;
  logic [READ_PORTS-1:0]            valid_q, valid_d;
  logic                             err_q, err_d;

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  active;
  logic                  wr_ok;
  logic                  wr_fire;

  regfile_clear_seq #(
    .MEM_SIZE       (MEM_SIZE),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk       (Clock),
    .rst_n     (Reset),
    .clear_req (iClear),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .ready     (oReady)
  );

  assign active  = ~clr_we;
  assign wr_ok   = in_range(iWriteAddress);
  assign wr_fire = active & iWriteEnable & wr_ok;

  // Clear writes take priority; user traffic is only live outside the clear sweep.
  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else if (wr_fire) begin
      mem_d[iWriteAddress] = iDataIn;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    data_d  = data_q;
    valid_d = '0;
    err_d   = active & iWriteEnable & ~wr_ok;
    ra      = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      ra = iReadAddress[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];
      if (active && iReadEnable[p]) begin
        valid_d[p] = 1'b1;
        if (!in_range(ra)) begin
          data_d[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = '0;
          err_d = 1'b1;
        end else if ((BYPASS != 0) && wr_fire && (ra == iWriteAddress)) begin
          data_d[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = iDataIn;
        end else begin
          data_d[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = mem_q[ra];
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; the clear sequencer zeroes it instead.
  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

  assign oDataOut   = data_q;
  assign oReadValid = valid_q;
  assign oError     = err_q;

endmodule

// File: tb/tb_regfile_multiport_clr.sv
// Directed bench: default instance (8 entries, bypass) and a 6-entry non-bypass instance
// share the same stimulus; expectations come from hand-maintained entry tables.
module tb_regfile_multiport_clr;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic        we    = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] din   = '0;
  logic [1:0]  re    = '0;
  logic [5:0]  raddr = '0;

  logic [31:0] dout_a, dout_b;
  logic [1:0]  rv_a, rv_b;
  logic        rdy_a, rdy_b, err_a, err_b;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] exp_a [8];
  logic [15:0] exp_b [6];

  always #5 clk = ~clk;

  regfile_multiport_clr u_dut_a (
    .Clock(clk), .Reset(rst_n), .iClear(clr), .iWriteEnable(we),
    .iWriteAddress(waddr), .iDataIn(din), .iReadEnable(re), .iReadAddress(raddr),
    .oDataOut(dout_a), .oReadValid(rv_a), .oReady(rdy_a), .oError(err_a)
  );

  regfile_multiport_clr #(.MEM_SIZE(6), .BYPASS(0)) u_dut_b (
    .Clock(clk), .Reset(rst_n), .iClear(clr), .iWriteEnable(we),
    .iWriteAddress(waddr), .iDataIn(din), .iReadEnable(re), .iReadAddress(raddr),
    .oDataOut(dout_b), .oReadValid(rv_b), .oReady(rdy_b), .oError(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nvec++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we  = 1'b0;
    clr = 1'b0;
    re  = '0;
  endtask

  task automatic readback(input string tag);
    idle();
    for (int a = 0; a < 8; a++) begin
      re    = 2'b11;
      raddr = {3'(a), 3'(a)};
      step();
      chk($sformatf("%s_a%0d", tag, a), dout_a, {exp_a[a], exp_a[a]});
      chk($sformatf("%s_va%0d", tag, a), 32'(rv_a), 32'h3);
      if (a < 6) begin
        chk($sformatf("%s_b%0d", tag, a), dout_b, {exp_b[a], exp_b[a]});
        chk($sformatf("%s_eb%0d", tag, a), 32'(err_b), 32'h0);
      end else begin
        chk($sformatf("%s_b%0d", tag, a), dout_b, 32'h0);
        chk($sformatf("%s_eb%0d", tag, a), 32'(err_b), 32'h1);
      end
    end
    idle();
  endtask

  initial begin
    foreach (exp_a[i]) exp_a[i] = '0;
    foreach (exp_b[i]) exp_b[i] = '0;

    // Reset state
    step();
    step();
    chk("rst_dout_a", dout_a, 32'h0);
    chk("rst_rv_a", 32'(rv_a), 32'h0);
    chk("rst_rdy_a", 32'(rdy_a), 32'h0);
    chk("rst_err_a", 32'(err_a), 32'h0);
    chk("rst_rdy_b", 32'(rdy_b), 32'h0);

    // Clear after reset: 8 clear edges for A, 6 for B
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("pclr_rdy_a_e%0d", i), 32'(rdy_a), 32'(i == 8));
      chk($sformatf("pclr_rdy_b_e%0d", i), 32'(rdy_b), 32'(i >= 6));
    end
    readback("post_reset");

    // Write then read on both ports
    we = 1'b1; waddr = 3'd3; din = 16'hA5A5;
    step();
    exp_a[3] = 16'hA5A5; exp_b[3] = 16'hA5A5;
    chk("wr_err_a", 32'(err_a), 32'h0);
    we = 1'b0; re = 2'b11; raddr = {3'd3, 3'd3};
    step();
    chk("wr_rd_a", dout_a, 32'hA5A5A5A5);
    chk("wr_rv_a", 32'(rv_a), 32'h3);
    chk("wr_rd_b", dout_b, 32'hA5A5A5A5);

    // Read-during-write: A bypasses, B returns old contents; port 1 holds
    re = 2'b00; we = 1'b1; waddr = 3'd5; din = 16'h1111;
    step();
    we = 1'b1; din = 16'h2222; re = 2'b01; raddr = {3'd3, 3'd5};
    step();
    exp_a[5] = 16'h2222; exp_b[5] = 16'h2222;
    chk("bypass_a", dout_a, {16'hA5A5, 16'h2222});
    chk("bypass_rv_a", 32'(rv_a), 32'h1);
    chk("nobypass_b", dout_b, {16'hA5A5, 16'h1111});
    we = 1'b0;
    step();
    chk("after_wr_b", dout_b, {16'hA5A5, 16'h2222});

    // Range errors on the 6-entry instance
    re = 2'b00; we = 1'b1; waddr = 3'd7; din = 16'hFFFF;
    step();
    exp_a[7] = 16'hFFFF;
    chk("oor_wr_err_b", 32'(err_b), 32'h1);
    chk("inr_wr_err_a", 32'(err_a), 32'h0);
    idle();
    step();
    chk("err_pulse_b", 32'(err_b), 32'h0);
    re = 2'b10; raddr = {3'd6, 3'd0};
    step();
    chk("oor_rd_err_b", 32'(err_b), 32'h1);
    chk("oor_rd_data_b", dout_b, {16'h0000, 16'h2222});
    chk("oor_rd_rv_b", 32'(rv_b), 32'h2);
    chk("inr_rd_a", dout_a, {16'h0000, 16'h2222});
    idle();
    step();
    chk("oor_err_clr_b", 32'(err_b), 32'h0);
    chk("oor_rv_clr_b", 32'(rv_b), 32'h0);
    readback("range");

    // Soft clear with traffic during the sweep
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); din = 16'h1000 + 16'(i);
      step();
      exp_a[i] = 16'h1000 + 16'(i);
      if (i < 6) exp_b[i] = 16'h1000 + 16'(i);
    end
    clr = 1'b1; we = 1'b1; waddr = 3'd0; din = 16'hBEEF; re = 2'b01; raddr = {3'd0, 3'd3};
    step();
    chk("sclr_req_rdy_a", 32'(rdy_a), 32'h0);
    chk("sclr_req_rv_a", 32'(rv_a), 32'h1);
    chk("sclr_req_dout_a", dout_a, {16'hFFFF, 16'h1003});
    clr = 1'b0; we = 1'b1; waddr = 3'd2; din = 16'hDEAD; re = 2'b11; raddr = {3'd4, 3'd4};
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("sclr_rdy_a_e%0d", i), 32'(rdy_a), 32'(i == 8));
      chk($sformatf("sclr_rv_a_e%0d", i), 32'(rv_a), 32'h0);
      chk($sformatf("sclr_hold_a_e%0d", i), dout_a, {16'hFFFF, 16'h1003});
      chk($sformatf("sclr_err_a_e%0d", i), 32'(err_a), 32'h0);
      chk($sformatf("sclr_rdy_b_e%0d", i), 32'(rdy_b), 32'(i >= 6));
    end
    foreach (exp_a[i]) exp_a[i] = '0;
    foreach (exp_b[i]) exp_b[i] = '0;
    exp_b[2] = 16'hDEAD;
    readback("sclr");

    // Reset in the 4th clear cycle
    we = 1'b1; waddr = 3'd1; din = 16'h1234;
    step();
    we = 1'b0; clr = 1'b1; re = 2'b01; raddr = {3'd0, 3'd1};
    step();
    chk("mid_pre_a", dout_a, {16'h0000, 16'h1234});
    idle();
    step();
    step();
    step();
    chk("mid_clear_rdy_a", 32'(rdy_a), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dout_a", dout_a, 32'h0);
    chk("mid_rst_dout_b", dout_b, 32'h0);
    chk("mid_rst_rv_a", 32'(rv_a), 32'h0);
    chk("mid_rst_err_a", 32'(err_a), 32'h0);
    chk("mid_rst_rdy_b", 32'(rdy_b), 32'h0);
    #3 rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("rerun_rdy_a_e%0d", i), 32'(rdy_a), 32'(i == 8));
    end
    foreach (exp_a[i]) exp_a[i] = '0;
    foreach (exp_b[i]) exp_b[i] = '0;
    readback("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
